// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler
//
// Sequences one convolution layer over NUM_KERNELS kernels. For each kernel it
// requests the weights, strobes the convolution FSM, gates the shift-register
// enable while the kernel runs, and then waits a fixed drain window for the
// output writeback. After the last kernel it pulses layer_done.
//
// Optional feature: define CONV_LAYER_SCHED_WATCHDOG_EN to enable the CONV-phase
// watchdog. When the macro is undefined, watchdog_err is tied low and CONV waits
// indefinitely for conv_done.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   layer_start       run a layer (accepted only when idle)
//   layer_abort       return to idle from any busy state, top priority
//   kernel_load_ack   weight loader finished the current kernel
//   row_shift_in_rdy  input row data valid this cycle
//   conv_done         single-cycle completion pulse from the convolution FSM
//   kernel_load_req   level request for the weights of kernel_index
//   kernel_index      current kernel, 0..NUM_KERNELS-1
//   input_start       start strobe to the convolution FSM
//   conv_enable       gated shift-register / FSM enable
//   busy              high whenever not idle
//   layer_done        one-cycle pulse at layer completion
//   watchdog_err      sticky watchdog expiry flag
module conv_layer_scheduler #(
  parameter int unsigned NUM_KERNELS     = 4,
  parameter int unsigned KERNEL_IDX_BW   = 2,
  parameter int unsigned DRAIN_CYCLES    = 4,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     layer_start,
  input  logic                     layer_abort,
  input  logic                     kernel_load_ack,
  input  logic                     row_shift_in_rdy,
  input  logic                     conv_done,
  output logic                     kernel_load_req,
  output logic [KERNEL_IDX_BW-1:0] kernel_index,
  output logic                     input_start,
  output logic                     conv_enable,
  output logic                     busy,
  output logic                     layer_done,
  output logic                     watchdog_err
);

  // Reject illegal configurations at elaboration time.
  if (NUM_KERNELS < 1 || NUM_KERNELS > (1 << KERNEL_IDX_BW) ||
      DRAIN_CYCLES < 1 || DRAIN_CYCLES > 65535 ||
      WATCHDOG_CYCLES < 1 || WATCHDOG_CYCLES > 65535) begin : gen_param_check
    $error("conv_layer_scheduler: illegal parameter combination");
  end

  localparam logic [15:0]              DrainLast  = 16'(DRAIN_CYCLES - 1);
  localparam logic [KERNEL_IDX_BW-1:0] LastKernel = KERNEL_IDX_BW'(NUM_KERNELS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StConv,
    StDrain,
    StDone
  } state_e;

  state_e                     state_q, state_d;
  logic [KERNEL_IDX_BW-1:0]   kidx_q, kidx_d;
  logic [15:0]                drain_q, drain_d;
  logic                       enable_window;

`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
  localparam logic [15:0] WdLast = 16'(WATCHDOG_CYCLES - 1);
  logic [15:0] wd_q, wd_d;
  logic        werr_q, werr_d;
`endif

  // State register and all sequential state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      kidx_q  <= '0;
      drain_q <= '0;
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
      wd_q    <= '0;
      werr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      kidx_q  <= kidx_d;
      drain_q <= drain_d;
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
      wd_q    <= wd_d;
      werr_q  <= werr_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    kidx_d  = kidx_q;
    drain_d = drain_q;
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
    wd_d    = wd_q;
    werr_d  = werr_q;
`endif
    if (layer_abort && (state_q != StIdle)) begin
      // Abort beats every same-cycle event; kernel_index is left as is.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (layer_start) begin
            state_d = StLoad;
            kidx_d  = '0;
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
            werr_d  = 1'b0;
`endif
          end
        end
        StLoad: begin
          if (kernel_load_ack) state_d = StStart;
        end
        StStart: begin
          // The convolution FSM samples input_start on the first rdy cycle.
          if (row_shift_in_rdy) begin
            state_d = StConv;
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
            wd_d    = '0;
`endif
          end
        end
        StConv: begin
          if (conv_done) begin
            state_d = StDrain;
            drain_d = '0;
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
          end else if (wd_q == WdLast) begin
            state_d = StIdle;
            werr_d  = 1'b1;
          end else begin
            wd_d    = wd_q + 16'd1;
`endif
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            if (kidx_q == LastKernel) begin
              state_d = StDone;
            end else begin
              state_d = StLoad;
              kidx_d  = kidx_q + KERNEL_IDX_BW'(1);
            end
          end else begin
            drain_d = drain_q + 16'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Moore outputs plus the rdy-gated enable.
  always_comb begin
    kernel_load_req = 1'b0;
    input_start     = 1'b0;
    busy            = 1'b1;
    layer_done      = 1'b0;
    enable_window   = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StLoad:  kernel_load_req = 1'b1;
      StStart: begin
        input_start   = 1'b1;
        enable_window = 1'b1;
      end
      StConv:  enable_window = 1'b1;
      StDone:  layer_done = 1'b1;
      default: ;
    endcase
    conv_enable = enable_window & row_shift_in_rdy;
  end

  assign kernel_index = kidx_q;

`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
  assign watchdog_err = werr_q;
`else
  assign watchdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_layer_scheduler.sv
`timescale 1ns/1ps
module tb_conv_layer_scheduler;
  localparam int NK = 4;
  localparam int IW = 2;
  localparam int DC = 4;
  localparam int WD = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          layer_start, layer_abort, kernel_load_ack, row_shift_in_rdy, conv_done;
  logic          kernel_load_req, input_start, conv_enable, busy, layer_done, watchdog_err;
  logic [IW-1:0] kernel_index;

  conv_layer_scheduler #(
    .NUM_KERNELS    (NK),
    .KERNEL_IDX_BW  (IW),
    .DRAIN_CYCLES   (DC),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .layer_start     (layer_start),
    .layer_abort     (layer_abort),
    .kernel_load_ack (kernel_load_ack),
    .row_shift_in_rdy(row_shift_in_rdy),
    .conv_done       (conv_done),
    .kernel_load_req (kernel_load_req),
    .kernel_index    (kernel_index),
    .input_start     (input_start),
    .conv_enable     (conv_enable),
    .busy            (busy),
    .layer_done      (layer_done),
    .watchdog_err    (watchdog_err)
  );

  always #5 clock = ~clock;

  // One scheduled cycle: inputs to drive and the full expected output vector
  // {req, index, input_start, conv_enable, busy, layer_done, watchdog_err}.
  typedef struct packed {
    logic       start;
    logic       abort;
    logic       ack;
    logic       rdy;
    logic       done;
    logic [7:0] exp;
  } cyc_t;

  cyc_t sched[$];
  int   total = 0;
  int   bad   = 0;
  int   ack_d  [NK];
  int   stall_d[NK];
  int   conv_d [NK];
  int   m_idx  = 0;
  bit   m_werr = 1'b0;
  int   noise  = 0;  // 0: quiet, 1: random ignored events, 2: ignored events every cycle

  function automatic logic [7:0] obs();
    return {kernel_load_req, kernel_index, input_start, conv_enable, busy, layer_done,
            watchdog_err};
  endfunction

  function automatic logic [7:0] ex(bit req, int idx, bit ist, bit cen, bit bz, bit ld);
    return {req, IW'(idx), ist, cen, bz, ld, m_werr};
  endfunction

  function automatic bit rb();
    if (noise == 0) return 1'b0;
    if (noise == 2) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit rr();
    if (noise == 0) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(bit s, bit a, bit k, bit r, bit d, logic [7:0] e);
    cyc_t c;
    c.start = s; c.abort = a; c.ack = k; c.rdy = r; c.done = d; c.exp = e;
    sched.push_back(c);
  endtask

  task automatic rand_delays();
    for (int k = 0; k < NK; k++) begin
      ack_d[k]   = $urandom_range(0, 3);
      stall_d[k] = $urandom_range(0, 3);
      conv_d[k]  = $urandom_range(1, 12);
    end
  endtask

  // Expected layer timeline from the phase lengths. cut_mode 1 aborts on the
  // first LOAD cycle of kernel cut_k (with ack in the same cycle); cut_mode 2
  // stops inside CONV of kernel cut_k without conv_done.
  task automatic build_layer(input int cut_k, input int cut_mode);
    bit r;
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, m_idx, 0, 0, 0, 0));
    m_werr = 1'b0;
    for (int k = 0; k < NK; k++) begin
      m_idx = k;
      if (cut_mode == 1 && k == cut_k) begin
        push(rb(), 1'b1, 1'b1, rr(), rb(), ex(1, k, 0, 0, 1, 0));
        return;
      end
      for (int i = 0; i <= ack_d[k]; i++)
        push(rb(), 1'b0, (i == ack_d[k]), rr(), rb(), ex(1, k, 0, 0, 1, 0));
      for (int i = 0; i <= stall_d[k]; i++) begin
        r = (i == stall_d[k]);
        push(rb(), 1'b0, rb(), r, rb(), ex(0, k, 1, r, 1, 0));
      end
      for (int i = 0; i < conv_d[k]; i++) begin
        r = rr();
        push(rb(), 1'b0, rb(), r, (i == conv_d[k] - 1) && !(cut_mode == 2 && k == cut_k),
             ex(0, k, 0, r, 1, 0));
      end
      if (cut_mode == 2 && k == cut_k) return;
      for (int i = 0; i < DC; i++)
        push(rb(), 1'b0, rb(), rr(), rb(), ex(0, k, 0, 0, 1, 0));
    end
    push(1'b1, 1'b0, 1'b0, rr(), rb(), ex(0, NK - 1, 0, 0, 1, 1));
    push(1'b0, 1'b0, 1'b0, rr(), rb(), ex(0, NK - 1, 0, 0, 0, 0));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      push(1'b0, 1'b0, rb(), rr(), rb(), ex(0, m_idx, 0, 0, 0, 0));
  endtask

  task automatic play(input string name);
    cyc_t        c;
    logic [7:0]  o;
    for (int i = 0; i < sched.size(); i++) begin
      c = sched[i];
      layer_start = c.start; layer_abort = c.abort; kernel_load_ack = c.ack;
      row_shift_in_rdy = c.rdy; conv_done = c.done;
      #1;
      o = obs();
      total++;
      if (o !== c.exp) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b want %b", name, i, o, c.exp);
      end
      @(posedge clock); #1;
    end
    sched.delete();
    layer_start = 0; layer_abort = 0; kernel_load_ack = 0; row_shift_in_rdy = 0; conv_done = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    layer_start = 0; layer_abort = 0; kernel_load_ack = 0; row_shift_in_rdy = 0; conv_done = 0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (obs() !== 8'h00) begin bad++; $display("FAIL reset_hold: got %b want 0", obs()); end
    reset = 1'b0;
    @(posedge clock); #1;
    total++;
    if (obs() !== 8'h00) begin bad++; $display("FAIL reset_release: got %b want 0", obs()); end
    m_idx = 0; m_werr = 1'b0;
  endtask

  task automatic test_full_layer();
    noise = 0;
    for (int k = 0; k < NK; k++) begin ack_d[k] = 2; stall_d[k] = 0; conv_d[k] = 10; end
    build_layer(0, 0);
    idle_cycles(2);
    play("full_layer");
  endtask

  task automatic test_start_stall();
    noise = 0;
    rand_delays();
    stall_d[0] = 5;
    build_layer(0, 0);
    play("start_stall");
  endtask

  task automatic test_ignored_events();
    noise = 2;
    rand_delays();
    build_layer(0, 0);
    play("ignored_events");
    noise = 0;
  endtask

  task automatic test_abort();
    noise = 1;
    rand_delays();
    build_layer(2, 1);
    idle_cycles(3);
    play("abort");
    rand_delays();
    build_layer(0, 0);
    play("abort_restart");
    noise = 0;
  endtask

  task automatic test_async_reset();
    noise = 0;
    rand_delays();
    conv_d[1] = 3;
    build_layer(1, 2);
    play("async_reset_lead");
    row_shift_in_rdy = 1'b1;
    #1;
    total++;
    if (obs() !== ex(0, 1, 0, 1, 1, 0)) begin
      bad++;
      $display("FAIL async_reset_pre: got %b want %b", obs(), ex(0, 1, 0, 1, 1, 0));
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (obs() !== 8'h00) begin bad++; $display("FAIL async_reset_mid: got %b want 0", obs()); end
    #1 reset = 1'b0;
    row_shift_in_rdy = 1'b0;
    @(posedge clock); #1;
    m_idx = 0;
    total++;
    if (obs() !== 8'h00) begin bad++; $display("FAIL async_reset_after: got %b want 0", obs()); end
  endtask

  task automatic test_random_layers();
    noise = 1;
    for (int n = 0; n < 6; n++) begin
      rand_delays();
      idle_cycles($urandom_range(0, 2));
      build_layer(0, 0);
    end
    play("random_layers");
    noise = 0;
  endtask

`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    noise = 0;
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, m_idx, 0, 0, 0, 0));
    m_werr = 1'b0; m_idx = 0;
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ex(1, 0, 0, 0, 1, 0));
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, 1, 1, 1, 0));
    for (int i = 0; i < WD; i++) push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, 0, 1, 1, 0));
    m_werr = 1'b1;
    idle_cycles(4);
    // Next layer clears the flag; conv_done on the expiry cycle wins.
    for (int k = 0; k < NK; k++) begin ack_d[k] = 1; stall_d[k] = 0; conv_d[k] = 4; end
    conv_d[0] = WD;
    build_layer(0, 0);
    play("watchdog");
  endtask
`else
  task automatic test_no_watchdog();
    noise = 1;
    rand_delays();
    conv_d[0] = 40;
    build_layer(0, 0);
    play("no_watchdog");
    noise = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_layer();
    test_start_stall();
    test_ignored_events();
    test_abort();
    test_async_reset();
    test_random_layers();
`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
Sequences one convolution layer over NUM_KERNELS kernels. Drives the convolution FSM and its shift registers once per kernel, and requests each kernel's weights from the weight loader. Sits between the layer-level host handshake and the convolution FSM / multiply-add tree datapath. Owns kernel ordering, start pulses, enable gating, drain timing and layer completion.

Parameters:
NUM_KERNELS, 4, kernels processed per layer (>=1)
KERNEL_IDX_BW, 2, width of kernel_index; 2^KERNEL_IDX_BW >= NUM_KERNELS
DRAIN_CYCLES, 4, idle cycles after conv_done before the next kernel; covers output writeback (1..65535)
WATCHDOG_CYCLES, 1024, max CONV cycles without conv_done (1..65535); used only with the optional feature

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
layer_start  in  1  request to run a layer; honoured only in IDLE
layer_abort  in  1  return to IDLE from any state next cycle
kernel_load_ack  in  1  weight loader finished loading the current kernel
row_shift_in_rdy  in  1  input row data valid this cycle
conv_done  in  1  single-cycle pulse from the convolution FSM (post tree delay)
kernel_load_req  out  1  level; requests weights for kernel_index
kernel_index  out  KERNEL_IDX_BW  current kernel, 0..NUM_KERNELS-1
input_start  out  1  start strobe to the convolution FSM
conv_enable  out  1  gated shift-register/FSM enable
busy  out  1  high in every state except IDLE
layer_done  out  1  one-cycle pulse at layer completion
watchdog_err  out  1  sticky error flag (optional feature)

Behaviour:
- Reset: state=IDLE. kernel_index=0, drain counter=0, watchdog counter=0, watchdog_err=0. All outputs 0.
- Moore outputs decode from the state register. conv_enable = row_shift_in_rdy AND state in {START,CONV}, and is combinational on row_shift_in_rdy.
- IDLE: layer_start=1 -> LOAD, kernel_index<=0.
- LOAD: kernel_load_req=1. kernel_load_ack=1 -> START. With no ack, hold indefinitely. ack in any other state is ignored.
- START: input_start=1. Leave to CONV on the first cycle with row_shift_in_rdy=1; that cycle is the one where the convolution FSM samples the start. With rdy=0, remain in START with input_start held.
- CONV: input_start=0. On conv_done=1 -> DRAIN, drain counter<=0.
- DRAIN: conv_enable=0. Counter increments each cycle. State lasts exactly DRAIN_CYCLES cycles, then:
  - if kernel_index==NUM_KERNELS-1 -> DONE;
  - else kernel_index<=kernel_index+1 -> LOAD.
- DONE: layer_done=1 for one cycle -> IDLE. kernel_index holds its last value until the next layer_start.
- conv_done outside CONV is ignored. layer_start outside IDLE is ignored, including in DONE.
- layer_abort has top priority in every non-IDLE state, including over same-cycle ack, conv_done or drain expiry. Next state is IDLE, with no layer_done pulse. kernel_index is unchanged until the next start.
- Reset asserted mid-operation behaves as power-on reset, asynchronously; outputs drop without waiting for a clock.
- Counters are 16-bit, compared against parameter-1, with no wrap inside legal parameter ranges.

Optional Feature:
Macro CONV_LAYER_SCHED_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on CONV entry and increments each CONV cycle.
  - If it reaches WATCHDOG_CYCLES-1 with no conv_done, the next state is IDLE and watchdog_err is set.
  - watchdog_err is sticky until reset or the next accepted layer_start. No layer_done pulse.
  - conv_done in the same cycle as expiry wins (normal DRAIN).
- Not defined: no counter logic; watchdog_err tied to 0; CONV waits indefinitely.

Test Plan:
1. Full layer:
   - Stimulus: NUM_KERNELS=4, DRAIN_CYCLES=4, rdy held 1, ack 2 cycles after each req, conv_done 10 cycles after each CONV entry.
   - Response: kernel_index 0,1,2,3; four single-cycle input_start pulses; DRAIN exactly 4 cycles each; one layer_done pulse; busy falls the cycle after.
2. Start stall:
   - Stimulus: rdy=0 for 5 cycles on START entry, then 1.
   - Response: input_start high 6 cycles; conv_enable 0 for the first 5, then 1; CONV entered after the 6th cycle.
3. Abort priority:
   - Stimulus: layer_abort and kernel_load_ack in the same cycle during LOAD of kernel 2.
   - Response: IDLE next cycle; kernel_load_req 0; no layer_done; kernel_index stays 2; next layer_start restarts at 0.
4. Ignored events:
   - Stimulus: layer_start during CONV; conv_done pulse during DRAIN.
   - Response: no state change; DRAIN still lasts exactly 4 cycles.
5. Async reset:
   - Stimulus: reset pulsed between clock edges in CONV of kernel 1.
   - Response: all outputs 0 before the next edge; state IDLE; kernel_index 0.
6. Watchdog (macro defined, WATCHDOG_CYCLES=16):
   - Stimulus: no conv_done.
   - Response: IDLE after 16 CONV cycles; watchdog_err=1 and stays 1; cleared by the next layer_start.
   - Variant: conv_done on cycle 16 -> DRAIN, watchdog_err=0.
